// File: rtl/axi4lite_master_ctrl_if.sv
// AXI4-Lite channel bundle shared by the command-port master and its slave.
interface axi4lite_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic A_CLK,
   input logic A_RSTn
);
   logic                    AW_VALID;
   logic                    AW_READY;
   logic [ADDR_WIDTH-1:0]   AW_ADDR;
   logic [2:0]              AW_PROT;
   logic                    W_VALID;
   logic                    W_READY;
   logic [DATA_WIDTH-1:0]   W_DATA;
   logic [DATA_WIDTH/8-1:0] W_STRB;
   logic                    B_VALID;
   logic                    B_READY;
   logic [1:0]              B_RESP;
   logic                    AR_VALID;
   logic                    AR_READY;
   logic [ADDR_WIDTH-1:0]   AR_ADDR;
   logic [2:0]              AR_PROT;
   logic                    R_VALID;
   logic                    R_READY;
   logic [DATA_WIDTH-1:0]   R_DATA;
   logic [1:0]              R_RESP;

   modport master (
      input  A_CLK, A_RSTn,
      output AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
      output AR_VALID, AR_ADDR, AR_PROT, R_READY,
      input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
   );

   modport slave (
      input  A_CLK, A_RSTn,
      input  AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
      input  AR_VALID, AR_ADDR, AR_PROT, R_READY,
      output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
   );
endinterface

// File: rtl/axi4lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI transaction
// and returns one response, with a watchdog on the B/R phase.
module axi4lite_master_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                    A_CLK,
   input  logic                    A_RSTn,
   input  logic                    CMD_VALID,
   output logic                    CMD_READY,
   input  logic                    CMD_WRITE,
   input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
   input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
   input  logic [DATA_WIDTH/8-1:0] CMD_STRB,
   output logic                    RSP_VALID,
   input  logic                    RSP_READY,
   output logic [DATA_WIDTH-1:0]   RSP_RDATA,
   output logic [1:0]              RSP_RESP,
   output logic                    RSP_TIMEOUT,
   axi4lite_if.master              axi_if
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

   state_t                  state, state_nxt;
   logic                    aw_done, aw_done_nxt;
   logic                    w_done, w_done_nxt;
   logic [CNT_WIDTH-1:0]    wd_cnt, wd_cnt_nxt;
   logic                    cmd_ready_nxt;
   logic                    rsp_valid_nxt, rsp_timeout_nxt;
   logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
   logic [1:0]              rsp_resp_nxt;
   logic                    aw_valid_nxt, w_valid_nxt, ar_valid_nxt, b_ready_nxt, r_ready_nxt;
   logic [ADDR_WIDTH-1:0]   aw_addr_nxt, ar_addr_nxt;
   logic [DATA_WIDTH-1:0]   w_data_nxt;
   logic [STRB_WIDTH-1:0]   w_strb_nxt;
   logic                    aw_hs_c, w_hs_c, ar_hs_c, b_hs_c, r_hs_c, wd_expired_c;

   // Protection attributes are fixed: unprivileged, secure, data access.
   assign axi_if.AW_PROT = 3'b000;
   assign axi_if.AR_PROT = 3'b000;

   // Next-state and next-output logic for the transaction sequencer.
   always_comb begin
      state_nxt       = state;
      aw_done_nxt     = aw_done;
      w_done_nxt      = w_done;
      wd_cnt_nxt      = wd_cnt;
      rsp_valid_nxt   = RSP_VALID;
      rsp_timeout_nxt = RSP_TIMEOUT;
      rsp_rdata_nxt   = RSP_RDATA;
      rsp_resp_nxt    = RSP_RESP;
      aw_valid_nxt    = axi_if.AW_VALID;
      w_valid_nxt     = axi_if.W_VALID;
      ar_valid_nxt    = axi_if.AR_VALID;
      b_ready_nxt     = axi_if.B_READY;
      r_ready_nxt     = axi_if.R_READY;
      aw_addr_nxt     = axi_if.AW_ADDR;
      ar_addr_nxt     = axi_if.AR_ADDR;
      w_data_nxt      = axi_if.W_DATA;
      w_strb_nxt      = axi_if.W_STRB;
      aw_hs_c         = axi_if.AW_VALID && axi_if.AW_READY;
      w_hs_c          = axi_if.W_VALID && axi_if.W_READY;
      ar_hs_c         = axi_if.AR_VALID && axi_if.AR_READY;
      b_hs_c          = axi_if.B_VALID && axi_if.B_READY;
      r_hs_c          = axi_if.R_VALID && axi_if.R_READY;
      wd_expired_c    = (TIMEOUT != 0) && (wd_cnt == CNT_WIDTH'(TIMEOUT - 1));

      case (state)
         IDLE: begin
            if (CMD_VALID && CMD_READY) begin
               if (CMD_WRITE) begin
                  state_nxt    = WR_AW_W;
                  aw_valid_nxt = 1'b1;
                  w_valid_nxt  = 1'b1;
                  aw_addr_nxt  = CMD_ADDR;
                  w_data_nxt   = CMD_WDATA;
                  w_strb_nxt   = CMD_STRB;
                  aw_done_nxt  = 1'b0;
                  w_done_nxt   = 1'b0;
               end else begin
                  state_nxt    = RD_AR;
                  ar_valid_nxt = 1'b1;
                  ar_addr_nxt  = CMD_ADDR;
               end
            end
         end
         WR_AW_W: begin
            if (aw_hs_c) begin
               aw_valid_nxt = 1'b0;
               aw_done_nxt  = 1'b1;
            end
            if (w_hs_c) begin
               w_valid_nxt = 1'b0;
               w_done_nxt  = 1'b1;
            end
            if ((aw_done || aw_hs_c) && (w_done || w_hs_c)) begin
               state_nxt   = WR_B;
               b_ready_nxt = 1'b1;
               wd_cnt_nxt  = '0;
            end
         end
         RD_AR: begin
            if (ar_hs_c) begin
               state_nxt    = RD_R;
               ar_valid_nxt = 1'b0;
               r_ready_nxt  = 1'b1;
               wd_cnt_nxt   = '0;
            end
         end
         WR_B: begin
            // A handshake in the expiry cycle still counts as a real response.
            if (b_hs_c || wd_expired_c) begin
               state_nxt       = RSP;
               b_ready_nxt     = 1'b0;
               rsp_valid_nxt   = 1'b1;
               rsp_rdata_nxt   = '0;
               rsp_resp_nxt    = b_hs_c ? axi_if.B_RESP : 2'b11;
               rsp_timeout_nxt = !b_hs_c;
            end else begin
               wd_cnt_nxt = wd_cnt + CNT_WIDTH'(1);
            end
         end
         RD_R: begin
            if (r_hs_c || wd_expired_c) begin
               state_nxt       = RSP;
               r_ready_nxt     = 1'b0;
               rsp_valid_nxt   = 1'b1;
               rsp_rdata_nxt   = r_hs_c ? axi_if.R_DATA : '0;
               rsp_resp_nxt    = r_hs_c ? axi_if.R_RESP : 2'b11;
               rsp_timeout_nxt = !r_hs_c;
            end else begin
               wd_cnt_nxt = wd_cnt + CNT_WIDTH'(1);
            end
         end
         RSP: begin
            if (RSP_VALID && RSP_READY) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase

      cmd_ready_nxt = (state_nxt == IDLE);
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge A_CLK or negedge A_RSTn) begin
      if (!A_RSTn) begin
         state            <= IDLE;
         aw_done          <= 1'b0;
         w_done           <= 1'b0;
         wd_cnt           <= '0;
         CMD_READY        <= 1'b0;
         RSP_VALID        <= 1'b0;
         RSP_TIMEOUT      <= 1'b0;
         RSP_RDATA        <= '0;
         RSP_RESP         <= 2'b00;
         axi_if.AW_VALID  <= 1'b0;
         axi_if.W_VALID   <= 1'b0;
         axi_if.AR_VALID  <= 1'b0;
         axi_if.B_READY   <= 1'b0;
         axi_if.R_READY   <= 1'b0;
         axi_if.AW_ADDR   <= '0;
         axi_if.AR_ADDR   <= '0;
         axi_if.W_DATA    <= '0;
         axi_if.W_STRB    <= '0;
      end else begin
         state            <= state_nxt;
         aw_done          <= aw_done_nxt;
         w_done           <= w_done_nxt;
         wd_cnt           <= wd_cnt_nxt;
         CMD_READY        <= cmd_ready_nxt;
         RSP_VALID        <= rsp_valid_nxt;
         RSP_TIMEOUT      <= rsp_timeout_nxt;
         RSP_RDATA        <= rsp_rdata_nxt;
         RSP_RESP         <= rsp_resp_nxt;
         axi_if.AW_VALID  <= aw_valid_nxt;
         axi_if.W_VALID   <= w_valid_nxt;
         axi_if.AR_VALID  <= ar_valid_nxt;
         axi_if.B_READY   <= b_ready_nxt;
         axi_if.R_READY   <= r_ready_nxt;
         axi_if.AW_ADDR   <= aw_addr_nxt;
         axi_if.AR_ADDR   <= ar_addr_nxt;
         axi_if.W_DATA    <= w_data_nxt;
         axi_if.W_STRB    <= w_strb_nxt;
      end
   end
endmodule

// File: tb/tb_axi4lite_master_ctrl.sv
// Bench for axi4lite_master_ctrl: small memory slave, response-level reference model,
// per-cycle compare process and directed tests with hand-computed expectations.
module tb_axi4lite_master_ctrl;
   logic        clk;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   int checks   = 0;
   int failures = 0;

   // slave behaviour knobs
   int   aw_wait = 0;
   int   w_wait  = 0;
   logic b_hang  = 1'b0;
   logic r_hang  = 1'b0;

   axi4lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi (.A_CLK(clk), .A_RSTn(rst_n));

   axi4lite_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
      .A_CLK(clk), .A_RSTn(rst_n),
      .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
      .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_STRB(cmd_strb),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
      .RSP_RESP(rsp_resp), .RSP_TIMEOUT(rsp_timeout), .axi_if(axi.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- memory slave (16 words, addresses >= 16 answer SLVERR) ----------------
   logic [31:0] s_mem [16];
   int          aw_seen, w_seen;
   logic        s_have_aw, s_have_w, s_bvalid, s_rvalid;
   logic [31:0] s_awaddr, s_wdata, s_rdata, s_wa, s_wd;
   logic [3:0]  s_wstrb, s_ws;
   logic [1:0]  s_bresp, s_rresp;
   logic        aw_hs, w_hs, ar_hs;

   assign axi.AW_READY = (aw_seen >= aw_wait);
   assign axi.W_READY  = (w_seen >= w_wait);
   assign axi.AR_READY = 1'b1;
   assign axi.B_VALID  = s_bvalid;
   assign axi.B_RESP   = s_bresp;
   assign axi.R_VALID  = s_rvalid;
   assign axi.R_DATA   = s_rdata;
   assign axi.R_RESP   = s_rresp;
   assign aw_hs = axi.AW_VALID && axi.AW_READY;
   assign w_hs  = axi.W_VALID && axi.W_READY;
   assign ar_hs = axi.AR_VALID && axi.AR_READY;
   assign s_wa  = aw_hs ? axi.AW_ADDR : s_awaddr;
   assign s_wd  = w_hs ? axi.W_DATA : s_wdata;
   assign s_ws  = w_hs ? axi.W_STRB : s_wstrb;

   always @(posedge axi.A_CLK or negedge axi.A_RSTn) begin
      if (!axi.A_RSTn) begin
         aw_seen <= 0; w_seen <= 0; s_have_aw <= 1'b0; s_have_w <= 1'b0;
         s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rresp <= 2'b00;
         s_rdata <= '0; s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      end else begin
         if (aw_hs) aw_seen <= 0; else if (axi.AW_VALID) aw_seen <= aw_seen + 1;
         if (w_hs) w_seen <= 0; else if (axi.W_VALID) w_seen <= w_seen + 1;
         if ((s_have_aw || aw_hs) && (s_have_w || w_hs)) begin
            if (s_wa < 16)
               for (int i = 0; i < 4; i++)
                  if (s_ws[i]) s_mem[s_wa[3:0]][8*i +: 8] <= s_wd[8*i +: 8];
            s_have_aw <= 1'b0;
            s_have_w  <= 1'b0;
            s_bvalid  <= !b_hang;
            s_bresp   <= (s_wa < 16) ? 2'b00 : 2'b10;
         end else begin
            if (aw_hs) begin s_have_aw <= 1'b1; s_awaddr <= axi.AW_ADDR; end
            if (w_hs) begin s_have_w <= 1'b1; s_wdata <= axi.W_DATA; s_wstrb <= axi.W_STRB; end
         end
         if (s_bvalid && axi.B_READY) s_bvalid <= 1'b0;
         if (ar_hs && !r_hang) begin
            s_rvalid <= 1'b1;
            s_rdata  <= (axi.AR_ADDR < 16) ? s_mem[axi.AR_ADDR[3:0]] : 32'h0;
            s_rresp  <= (axi.AR_ADDR < 16) ? 2'b00 : 2'b10;
         end
         if (s_rvalid && axi.R_READY) s_rvalid <= 1'b0;
      end
   end

   // ---------------- reference model: expected responses per command ----------------
   typedef struct { logic [31:0] rdata; logic [1:0] resp; logic to; } exp_t;
   exp_t        exp_q [$];
   logic [31:0] m_mem [16];
   logic        m_busy, m_started;

   initial begin
      for (int i = 0; i < 16; i++) begin s_mem[i] = '0; m_mem[i] = '0; end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         m_busy    <= 1'b0;
         m_started <= 1'b0;
      end else begin
         m_started <= 1'b1;
         if (cmd_valid && cmd_ready) begin
            exp_t e;
            logic in_range;
            in_range = (cmd_addr < 16);
            if (cmd_write) begin
               if (in_range)
                  for (int i = 0; i < 4; i++)
                     if (cmd_strb[i]) m_mem[cmd_addr[3:0]][8*i +: 8] <= cmd_wdata[8*i +: 8];
               e.rdata = '0;
               e.resp  = b_hang ? 2'b11 : (in_range ? 2'b00 : 2'b10);
               e.to    = b_hang;
            end else begin
               e.rdata = (r_hang || !in_range) ? 32'h0 : m_mem[cmd_addr[3:0]];
               e.resp  = r_hang ? 2'b11 : (in_range ? 2'b00 : 2'b10);
               e.to    = r_hang;
            end
            exp_q.push_back(e);
            m_busy <= 1'b1;
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_busy <= 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs", 64'({cmd_ready, rsp_valid, rsp_timeout, |rsp_rdata, |rsp_resp,
             axi.AW_VALID, axi.W_VALID, axi.AR_VALID, axi.B_READY, axi.R_READY,
             |axi.AW_ADDR, |axi.AR_ADDR, |axi.W_DATA, |axi.W_STRB}), 64'h0);
      end else begin
         chk("cmd_ready", 64'(cmd_ready), 64'(m_started && !m_busy));
         chk("prot", 64'({axi.AW_PROT, axi.AR_PROT}), 64'h0);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
            end else begin
               chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
               chk("rsp_resp", 64'(rsp_resp), 64'(exp_q[0].resp));
               chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_q[0].to));
            end
         end
      end
   end

   // ---------------- directed command driver ----------------
   typedef struct {
      int rsp_cyc; int aw_c; int w_c; int ar_c; int br_c; int rr_c;
      int b_hs; int rv_c; int cr_c;
      logic [31:0] rdata; logic [1:0] resp; logic to;
   } res_t;

   // Called and returns at a negedge; cycle 1 is the cycle after the command handshake.
   task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold, output res_t r);
      int cyc;
      int wait_c;
      r = '{rsp_cyc: -1, default: 0};
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_strb = strb;
      wait_c = 0;
      while (!cmd_ready && wait_c < 20) begin @(negedge clk); wait_c++; end
      if (!cmd_ready) begin
         chk("cmd_accept", 64'(cmd_ready), 64'h1);
         cmd_valid = 1'b0;
         return;
      end
      @(negedge clk);
      // later changes to the command inputs must be ignored
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~data; cmd_strb = ~strb;
      cyc = 1;
      while (cyc < 60) begin
         if (axi.AW_VALID) r.aw_c++;
         if (axi.W_VALID)  r.w_c++;
         if (axi.AR_VALID) r.ar_c++;
         if (axi.B_READY)  r.br_c++;
         if (axi.R_READY)  r.rr_c++;
         if (cmd_ready)    r.cr_c++;
         if (axi.B_VALID && axi.B_READY) r.b_hs++;
         if (rsp_valid) begin
            r.rv_c++;
            if (r.rsp_cyc < 0) begin
               r.rsp_cyc = cyc; r.rdata = rsp_rdata; r.resp = rsp_resp; r.to = rsp_timeout;
            end
            if (cyc - r.rsp_cyc >= hold) begin
               rsp_ready = 1'b1;
               @(negedge clk);
               rsp_ready = 1'b0;
               chk("rsp_drop", 64'(rsp_valid), 64'h0);
               chk("idle_ready", 64'(cmd_ready), 64'h1);
               return;
            end
         end
         @(negedge clk);
         cyc++;
      end
      chk("rsp_seen", 64'(rsp_valid), 64'h1);
   endtask

   res_t r;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("ready_low_after_release", 64'(cmd_ready), 64'h0);
      @(negedge clk);
      chk("ready_first_edge", 64'(cmd_ready), 64'h1);

      // 1: zero-wait write
      run_cmd(1'b1, 32'd1, 32'h1, 4'hF, 0, r);
      chk("t1_lat", 64'(r.rsp_cyc), 64'd3);
      chk("t1_aw_cycles", 64'(r.aw_c), 64'd1);
      chk("t1_w_cycles", 64'(r.w_c), 64'd1);
      chk("t1_resp", 64'(r.resp), 64'h0);
      chk("t1_timeout", 64'(r.to), 64'h0);
      chk("t1_rdata", 64'(r.rdata), 64'h0);

      // 2: read back
      run_cmd(1'b0, 32'd1, 32'h0, 4'h0, 0, r);
      chk("t2_lat", 64'(r.rsp_cyc), 64'd3);
      chk("t2_ar_cycles", 64'(r.ar_c), 64'd1);
      chk("t2_rdata", 64'(r.rdata), 64'h1);
      chk("t2_resp", 64'(r.resp), 64'h0);

      // 3: AW accepted 3 cycles before W, partial strobes
      w_wait = 3;
      run_cmd(1'b1, 32'd3, 32'hA5A5_1234, 4'b0101, 0, r);
      w_wait = 0;
      chk("t3_aw_cycles", 64'(r.aw_c), 64'd1);
      chk("t3_w_cycles", 64'(r.w_c), 64'd4);
      chk("t3_b_count", 64'(r.b_hs), 64'd1);
      chk("t3_lat", 64'(r.rsp_cyc), 64'd6);
      run_cmd(1'b0, 32'd3, 32'h0, 4'h0, 0, r);
      chk("t3_rdata", 64'(r.rdata), 64'h00A5_0034);

      // W accepted before AW
      aw_wait = 2;
      run_cmd(1'b1, 32'd4, 32'hCAFE_F00D, 4'hF, 0, r);
      aw_wait = 0;
      chk("t3b_aw_cycles", 64'(r.aw_c), 64'd3);
      chk("t3b_w_cycles", 64'(r.w_c), 64'd1);
      chk("t3b_lat", 64'(r.rsp_cyc), 64'd5);

      // 4: read watchdog with TIMEOUT=8
      r_hang = 1'b1;
      run_cmd(1'b0, 32'd1, 32'h0, 4'h0, 0, r);
      r_hang = 1'b0;
      chk("t4_rready_cycles", 64'(r.rr_c), 64'd8);
      chk("t4_lat", 64'(r.rsp_cyc), 64'd10);
      chk("t4_resp", 64'(r.resp), 64'h3);
      chk("t4_timeout", 64'(r.to), 64'h1);
      chk("t4_rdata", 64'(r.rdata), 64'h0);

      // 5: response back-pressure
      run_cmd(1'b0, 32'd1, 32'h0, 4'h0, 5, r);
      chk("t5_rdata", 64'(r.rdata), 64'h1);
      chk("t5_rsp_cycles", 64'(r.rv_c), 64'd6);
      chk("t5_cmd_ready_busy", 64'(r.cr_c), 64'd0);

      // out-of-range address returns SLVERR
      run_cmd(1'b1, 32'd20, 32'h1234_5678, 4'hF, 0, r);
      chk("oor_wr_resp", 64'(r.resp), 64'h2);
      run_cmd(1'b0, 32'd20, 32'h0, 4'h0, 0, r);
      chk("oor_rd_resp", 64'(r.resp), 64'h2);
      chk("oor_rd_rdata", 64'(r.rdata), 64'h0);

      // 6: reset while waiting for B
      b_hang = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd2; cmd_wdata = 32'h22; cmd_strb = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 20 && !axi.B_READY; i++) @(negedge clk);
      chk("t6_in_wr_b", 64'(axi.B_READY), 64'h1);
      #2 rst_n = 1'b0;
      #1 chk("t6_async_clear", 64'({axi.AW_VALID, axi.W_VALID, axi.AR_VALID, axi.B_READY,
                                    axi.R_READY, rsp_valid, cmd_ready}), 64'h0);
      repeat (2) @(negedge clk);
      b_hang = 1'b0;
      rst_n  = 1'b1;
      @(negedge clk);
      chk("t6_ready_after_reset", 64'(cmd_ready), 64'h1);
      run_cmd(1'b0, 32'd1, 32'h0, 4'h0, 0, r);
      chk("t6_lat", 64'(r.rsp_cyc), 64'd3);
      chk("t6_rdata", 64'(r.rdata), 64'h1);
      chk("t6_resp", 64'(r.resp), 64'h0);
      run_cmd(1'b0, 32'd2, 32'h0, 4'h0, 0, r);
      chk("t6_rdata_addr2", 64'(r.rdata), 64'h22);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_time_limit: got expired expected done");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
